frv_axi_sram_responder: RTL and testbench
=========================================

FRV_AXI_SRAM_RESPONDER -- requirements
Module: frv_axi_sram_responder

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h8000_0000, byte base address of the responder window.
REQ-002 SHALL have parameter ADDR_W, default 10, SRAM word-address width; window size = 4*2^ADDR_W bytes.
REQ-003 SHALL have port g_clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port g_resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_awvalid  in  1  write address valid.
REQ-006 SHALL have port s_awready  out  1  write address ready.
REQ-007 SHALL have port s_awaddr  in  32  write byte address.
REQ-008 SHALL have port s_wvalid  in  1  write data valid.
REQ-009 SHALL have port s_wready  out  1  write data ready.
REQ-010 SHALL have port s_wdata  in  32  write data.
REQ-011 SHALL have port s_wstrb  in  4  write byte strobes.
REQ-012 SHALL have port s_bvalid  out  1  write response valid.
REQ-013 SHALL have port s_bready  in  1  write response ready.
REQ-014 SHALL have port s_bresp  out  2  write response code.
REQ-015 SHALL have port s_arvalid  in  1  read address valid.
REQ-016 SHALL have port s_arready  out  1  read address ready.
REQ-017 SHALL have port s_araddr  in  32  read byte address.
REQ-018 SHALL have port s_rvalid  out  1  read data valid.
REQ-019 SHALL have port s_rready  in  1  read data ready.
REQ-020 SHALL have port s_rdata  out  32  read data.
REQ-021 SHALL have port s_rresp  out  2  read response code.
REQ-022 SHALL have port sram_cen  out  1  SRAM access enable, one cycle per access.
REQ-023 SHALL have port sram_wen  out  1  SRAM write enable, qualified by sram_cen.
REQ-024 SHALL have port sram_strb  out  4  SRAM byte write strobes.
REQ-025 SHALL have port sram_addr  out  ADDR_W  SRAM word address, byte address bits [ADDR_W+1:2].
REQ-026 SHALL have port sram_wdata  out  32  SRAM write data.
REQ-027 SHALL have port sram_rdata  in  32  SRAM read data, valid the cycle after a read sram_cen.

Function
REQ-028 SHALL implement FSM states IDLE, WR_ACC, WR_DO, WR_RSP, RD_DO, RD_CAP, RD_RSP.
REQ-029 SHALL, in IDLE/WR_ACC, hold s_awready high until an AW beat is latched and s_wready high until a W beat is latched, independently and in either order; FSM SHALL enter WR_ACC once one is latched and WR_DO once both are latched.
REQ-030 SHALL, in WR_DO, pulse sram_cen=1, sram_wen=1 for exactly one cycle with latched strobe/data/address, then enter WR_RSP.
REQ-031 SHALL, in WR_RSP, hold s_bvalid=1 and s_bresp stable until s_bready, then return to IDLE in the following cycle.
REQ-032 SHALL assert s_arready only in IDLE, and only when no AW/W beat is latched and not (s_awvalid and s_wvalid); write wins all simultaneous contention.
REQ-033 SHALL, after an AR handshake, pass RD_DO (sram_cen=1, sram_wen=0), RD_CAP (register sram_rdata), RD_RSP; s_rvalid SHALL rise 3 cycles after the AR handshake cycle.
REQ-034 SHALL hold s_rvalid, s_rdata, s_rresp stable in RD_RSP until s_rready, then return to IDLE.
REQ-035 SHALL ignore byte-address bits [1:0]; no unaligned handling; only one outstanding transaction at any time.

Reset
REQ-036 SHALL, on g_resetn=0 in any state, enter IDLE, drop latched AW/W beats and drive s_awready, s_wready, s_bvalid, s_arready, s_rvalid, sram_cen, sram_wen to 0, and s_bresp, s_rresp, s_rdata to 0, from the next edge.
REQ-037 SHALL discard an in-flight transaction on reset mid-operation; no response is issued for it.

Configuration
REQ-038 SHALL, with FRV_AXI_RSP_RANGE_CHECK_EN defined, treat addresses outside [MEM_BASE, MEM_BASE+4*2^ADDR_W) as errors: no sram_cen pulse, response 2'b10 (SLVERR), s_rdata=0, same latency.
REQ-039 SHALL, without FRV_AXI_RSP_RANGE_CHECK_EN, truncate all addresses to bits [ADDR_W+1:2] and always respond 2'b00 (OKAY).

Verification
REQ-040 SHALL pass: AW 0x8000_0010 then W 0xDEADBEEF strb 4'hF two cycles later -> one sram_cen/sram_wen pulse, sram_addr=4; bvalid with bresp=0.
REQ-041 SHALL pass: AR 0x8000_0010 with sram_rdata=0xDEADBEEF after the read cycle -> s_rvalid 3 cycles after handshake, s_rdata=0xDEADBEEF, rresp=0.
REQ-042 SHALL pass: awvalid, wvalid, arvalid asserted in the same cycle -> write completes first (bvalid), then AR is accepted.
REQ-043 SHALL pass: s_rready held low for 5 cycles -> s_rvalid/s_rdata stable throughout; s_arready stays 0.
REQ-044 SHALL pass, with FRV_AXI_RSP_RANGE_CHECK_EN defined: AR 0x0000_1000 -> rresp=2'b10, s_rdata=0, no sram_cen.
REQ-045 SHALL pass: g_resetn low during RD_CAP -> next cycle IDLE, s_rvalid never asserted.

Source files
------------

// File: rtl/frv_axi_sram_responder.sv
// AXI4-Lite slave in front of a single-port synchronous SRAM; one transaction at a time, writes win contention.
// Define FRV_AXI_RSP_RANGE_CHECK_EN to answer accesses outside the window with SLVERR instead of aliasing them.
module frv_axi_sram_responder #(
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [31:0]       s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [3:0]        sram_strb,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [2:0] {IDLE, WR_ACC, WR_DO, WR_RSP, RD_DO, RD_CAP, RD_RSP} state_t;

  state_t      state_q, state_d;
  logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [31:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic        aw_hs, w_hs, ar_hs, wr_err, rd_err;

`ifdef FRV_AXI_RSP_RANGE_CHECK_EN
  // 33-bit offset so addresses below MEM_BASE wrap to a huge value and fail the compare
  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_W;
  logic [32:0] wr_off, rd_off;
  assign wr_off = {1'b0, awaddr_q} - {1'b0, MEM_BASE};
  assign rd_off = {1'b0, araddr_q} - {1'b0, MEM_BASE};
  assign wr_err = (wr_off >= WIN_BYTES);
  assign rd_err = (rd_off >= WIN_BYTES);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr_q[31:ADDR_W+2], awaddr_q[1:0],
                              araddr_q[31:ADDR_W+2], araddr_q[1:0]};
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign s_awready = g_resetn && (state_q == IDLE || state_q == WR_ACC) && !aw_got_q;
  assign s_wready  = g_resetn && (state_q == IDLE || state_q == WR_ACC) && !w_got_q;
  // Any pending write intent blocks AR so a read can never slip in between AW and W
  assign s_arready = g_resetn && (state_q == IDLE) && !aw_got_q && !w_got_q
                     && !s_awvalid && !s_wvalid;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  assign s_bvalid   = (state_q == WR_RSP);
  assign s_rvalid   = (state_q == RD_RSP);
  assign s_bresp    = bresp_q;
  assign s_rresp    = rresp_q;
  assign s_rdata    = rdata_q;
  assign sram_cen   = ((state_q == WR_DO) && !wr_err) || ((state_q == RD_DO) && !rd_err);
  assign sram_wen   = (state_q == WR_DO) && !wr_err;
  assign sram_strb  = wstrb_q;
  assign sram_wdata = wdata_q;
  assign sram_addr  = (state_q == RD_DO) ? araddr_q[ADDR_W+1:2] : awaddr_q[ADDR_W+1:2];

  always_comb begin
    state_d  = state_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    awaddr_d = awaddr_q;
    araddr_d = araddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    bresp_d  = bresp_q;
    rresp_d  = rresp_q;
    if (aw_hs) begin
      aw_got_d = 1'b1;
      awaddr_d = s_awaddr;
    end
    if (w_hs) begin
      w_got_d = 1'b1;
      wdata_d = s_wdata;
      wstrb_d = s_wstrb;
    end
    case (state_q)
      IDLE: begin
        if (aw_got_d && w_got_d) begin
          state_d = WR_DO;
        end else if (aw_got_d || w_got_d) begin
          state_d = WR_ACC;
        end else if (ar_hs) begin
          araddr_d = s_araddr;
          state_d  = RD_DO;
        end
      end
      WR_ACC: if (aw_got_d && w_got_d) state_d = WR_DO;
      WR_DO: begin
        aw_got_d = 1'b0;
        w_got_d  = 1'b0;
        bresp_d  = wr_err ? 2'b10 : 2'b00;
        state_d  = WR_RSP;
      end
      WR_RSP: if (s_bready) state_d = IDLE;
      RD_DO:  state_d = RD_CAP;
      RD_CAP: begin
        rdata_d = rd_err ? 32'h0 : sram_rdata;
        rresp_d = rd_err ? 2'b10 : 2'b00;
        state_d = RD_RSP;
      end
      RD_RSP: if (s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q  <= IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      awaddr_q <= 32'h0;
      araddr_q <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      rdata_q  <= 32'h0;
      bresp_q  <= 2'b00;
      rresp_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      awaddr_q <= awaddr_d;
      araddr_q <= araddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: tb/tb_frv_axi_sram_responder.sv
// Bench for frv_axi_sram_responder: directed AXI-Lite traffic, SRAM model, queued expectations checked by a monitor.
module tb_frv_axi_sram_responder;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
  logic        s_bready = 1'b1, s_rready = 1'b1;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic        sram_cen, sram_wen;
  logic [3:0]  sram_strb;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;

  always #5 g_clk = ~g_clk;

  frv_axi_sram_responder dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_strb(sram_strb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  logic [31:0] mem [0:1023];
  always @(posedge g_clk) begin
    if (sram_cen) begin
      if (sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (sram_strb[b]) mem[sram_addr][b*8 +: 8] = sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {bit wen; logic [9:0] addr; logic [31:0] wdata; logic [3:0] strb;} acc_t;
  typedef struct {bit rd; logic [1:0] resp; logic [31:0] data;} rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  acc_t ea;
  rsp_t er;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge g_clk) begin
    if (g_resetn) begin
      if (sram_cen) begin
        if (acc_q.size() == 0) chk("sram_unexpected_cen", 32'(sram_cen), 32'd0);
        else begin
          ea = acc_q.pop_front();
          chk("sram_wen", 32'(sram_wen), 32'(ea.wen));
          chk("sram_addr", 32'(sram_addr), 32'(ea.addr));
          if (ea.wen) begin
            chk("sram_wdata", sram_wdata, ea.wdata);
            chk("sram_strb", 32'(sram_strb), 32'(ea.strb));
          end
        end
      end
      if (s_bvalid && s_bready) begin
        if (rsp_q.size() == 0) chk("b_unexpected", 32'(s_bvalid), 32'd0);
        else begin
          er = rsp_q.pop_front();
          chk("b_order", 32'(er.rd), 32'd0);
          chk("bresp", 32'(s_bresp), 32'(er.resp));
        end
      end
      if (s_rvalid && s_rready) begin
        if (rsp_q.size() == 0) chk("r_unexpected", 32'(s_rvalid), 32'd0);
        else begin
          er = rsp_q.pop_front();
          chk("r_order", 32'(er.rd), 32'd1);
          chk("rresp", 32'(s_rresp), 32'(er.resp));
          chk("rdata", s_rdata, er.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic aw_beat(input logic [31:0] a);
    int n;
    n = 0;
    s_awvalid = 1'b1;
    s_awaddr  = a;
    @(negedge g_clk);
    while (!s_awready && n < 40) begin @(negedge g_clk); n++; end
    chk("aw_accept", 32'(s_awready), 32'd1);
    tick();
    s_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    s_wvalid = 1'b1;
    s_wdata  = d;
    s_wstrb  = s;
    @(negedge g_clk);
    while (!s_wready && n < 40) begin @(negedge g_clk); n++; end
    chk("w_accept", 32'(s_wready), 32'd1);
    tick();
    s_wvalid = 1'b0;
  endtask

  task automatic ar_beat(input logic [31:0] a);
    int n;
    n = 0;
    s_arvalid = 1'b1;
    s_araddr  = a;
    @(negedge g_clk);
    while (!s_arready && n < 40) begin @(negedge g_clk); n++; end
    chk("ar_accept", 32'(s_arready), 32'd1);
    tick();
    s_arvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || acc_q.size() != 0) && n < 60) begin @(negedge g_clk); n++; end
    chk("drain_pending", 32'(rsp_q.size() + acc_q.size()), 32'd0);
    tick();
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp, input bit exp_cen, input logic [9:0] exp_addr,
                           input int gap, input bit w_first);
    if (exp_cen) acc_q.push_back('{1'b1, exp_addr, d, s});
    rsp_q.push_back('{1'b0, resp, 32'h0});
    if (w_first) begin
      w_beat(d, s);
      repeat (gap) tick();
      aw_beat(a);
    end else begin
      aw_beat(a);
      repeat (gap) tick();
      w_beat(d, s);
    end
    drain();
  endtask

  task automatic read_txn(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                          input bit exp_cen, input logic [9:0] exp_addr);
    int n;
    if (exp_cen) acc_q.push_back('{1'b0, exp_addr, 32'h0, 4'h0});
    rsp_q.push_back('{1'b1, resp, d});
    ar_beat(a);
    n = 0;
    do begin @(negedge g_clk); n++; end while (!s_rvalid && n < 20);
    chk("rvalid_latency", 32'(n), 32'd3);
    drain();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  saw_rv;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | 32'(i);

    repeat (3) tick();
    chk("rst_awready", 32'(s_awready), 32'd0);
    chk("rst_wready", 32'(s_wready), 32'd0);
    chk("rst_arready", 32'(s_arready), 32'd0);
    chk("rst_bvalid", 32'(s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_rvalid), 32'd0);
    chk("rst_cen", 32'(sram_cen), 32'd0);
    chk("rst_wen", 32'(sram_wen), 32'd0);
    chk("rst_resp", 32'({s_bresp, s_rresp}), 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    g_resetn = 1'b1;
    @(negedge g_clk);
    chk("idle_awready", 32'(s_awready), 32'd1);
    chk("idle_arready", 32'(s_arready), 32'd1);
    tick();

    // AW then W two cycles later; then read back, including an unaligned alias
    write_txn(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b1, 10'h004, 2, 1'b0);
    read_txn(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1'b1, 10'h004);
    read_txn(32'h8000_0013, 32'hDEAD_BEEF, 2'b00, 1'b1, 10'h004);

    // W before AW, partial strobes, B held off by bready
    s_bready = 1'b0;
    acc_q.push_back('{1'b1, 10'h005, 32'h0BAD_F00D, 4'b1100});
    rsp_q.push_back('{1'b0, 2'b00, 32'h0});
    w_beat(32'h0BAD_F00D, 4'b1100);
    aw_beat(32'h8000_0014);
    n = 0;
    @(negedge g_clk);
    while (!s_bvalid && n < 20) begin @(negedge g_clk); n++; end
    chk("b_arrive", 32'(s_bvalid), 32'd1);
    repeat (3) begin
      @(negedge g_clk);
      chk("b_hold_valid", 32'(s_bvalid), 32'd1);
      chk("b_hold_arready", 32'(s_arready), 32'd0);
    end
    @(posedge g_clk); #1;
    s_bready = 1'b1;
    drain();

    // AW, W and AR together: write must finish before AR is taken
    acc_q.push_back('{1'b1, 10'h008, 32'h1234_5678, 4'b0101});
    acc_q.push_back('{1'b0, 10'h008, 32'h0, 4'h0});
    rsp_q.push_back('{1'b0, 2'b00, 32'h0});
    rsp_q.push_back('{1'b1, 2'b00, 32'hA534_0078});
    s_awvalid = 1'b1; s_awaddr = 32'h8000_0020;
    s_wvalid  = 1'b1; s_wdata  = 32'h1234_5678; s_wstrb = 4'b0101;
    s_arvalid = 1'b1; s_araddr = 32'h8000_0020;
    @(negedge g_clk);
    chk("contend_arready", 32'(s_arready), 32'd0);
    chk("contend_awready", 32'(s_awready), 32'd1);
    chk("contend_wready", 32'(s_wready), 32'd1);
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    n = 0;
    @(negedge g_clk);
    while (!s_arready && n < 40) begin @(negedge g_clk); n++; end
    chk("contend_ar_accept", 32'(s_arready), 32'd1);
    chk("contend_b_first", 32'(rsp_q.size()), 32'd1);
    tick();
    s_arvalid = 1'b0;
    drain();

    // R held off for 5 cycles
    s_rready = 1'b0;
    acc_q.push_back('{1'b0, 10'h005, 32'h0, 4'h0});
    rsp_q.push_back('{1'b1, 2'b00, 32'h0BAD_0005});
    ar_beat(32'h8000_0014);
    n = 0;
    @(negedge g_clk);
    while (!s_rvalid && n < 20) begin @(negedge g_clk); n++; end
    chk("r_arrive", 32'(s_rvalid), 32'd1);
    repeat (5) begin
      @(negedge g_clk);
      chk("r_hold_valid", 32'(s_rvalid), 32'd1);
      chk("r_hold_data", s_rdata, 32'h0BAD_0005);
      chk("r_hold_arready", 32'(s_arready), 32'd0);
    end
    @(posedge g_clk); #1;
    s_rready = 1'b1;
    drain();

`ifdef FRV_AXI_RSP_RANGE_CHECK_EN
    read_txn(32'h0000_1000, 32'h0, 2'b10, 1'b0, 10'h000);
    write_txn(32'h9000_0004, 32'hCAFE_F00D, 4'hF, 2'b10, 1'b0, 10'h000, 0, 1'b0);
    read_txn(32'h8000_0FFC, 32'hA5A5_03FF, 2'b00, 1'b1, 10'h3FF);
    read_txn(32'h8000_0004, 32'hA5A5_0001, 2'b00, 1'b1, 10'h001);
`else
    read_txn(32'h0000_1000, 32'hA5A5_0000, 2'b00, 1'b1, 10'h000);
    write_txn(32'h9000_0004, 32'hCAFE_F00D, 4'hF, 2'b00, 1'b1, 10'h001, 0, 1'b0);
    read_txn(32'h8000_0004, 32'hCAFE_F00D, 2'b00, 1'b1, 10'h001);
`endif

    // Reset while the read sits in RD_CAP: no response may ever appear
    acc_q.push_back('{1'b0, 10'h00C, 32'h0, 4'h0});
    ar_beat(32'h8000_0030);
    tick();
    g_resetn = 1'b0;
    tick();
    chk("midrst_rvalid", 32'(s_rvalid), 32'd0);
    chk("midrst_rdata", s_rdata, 32'd0);
    chk("midrst_arready", 32'(s_arready), 32'd0);
    chk("midrst_cen", 32'(sram_cen), 32'd0);
    chk("midrst_acc_done", 32'(acc_q.size()), 32'd0);
    tick();
    g_resetn = 1'b1;
    saw_rv = 1'b0;
    repeat (8) begin
      @(negedge g_clk);
      if (s_rvalid) saw_rv = 1'b1;
    end
    chk("midrst_no_rvalid", 32'(saw_rv), 32'd0);
    chk("midrst_idle_arready", 32'(s_arready), 32'd1);
    tick();

    read_txn(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1'b1, 10'h004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
